// File: rtl/sd_decimator.sv
// sd_decimator: two-bit-per-clock sigma-delta decimator.
// Each qualified clock (en=1) adds popcount(sd_in) to an accumulator; after DECIM
// qualified clocks the window sum is dumped to dout behind a valid/ready handshake.
// A dump while an unconsumed sample is pending and the consumer is not ready
// overwrites dout and sets the sticky ovr flag.
// Build option: define SD_DECIM_SIGNED_EN to present dout as the bipolar value
// (window sum - DECIM) in two's complement; otherwise dout is the unsigned sum.
// Legal parameters: 2 <= DECIM <= 65535 and 2**OUTW > 2*DECIM.
module sd_decimator #(
    parameter int DECIM = 256,
    parameter int OUTW  = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      sd_in,
    input  logic            en,
    output logic [OUTW-1:0] dout,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            ovr,
    input  logic            ovr_clr
);

    localparam int CNT_W = $clog2(DECIM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    // Number of ones among the two modulator bits, widened to the accumulator width.
    function automatic logic [OUTW-1:0] popcount2(input logic [1:0] bits);
        return OUTW'(bits[0]) + OUTW'(bits[1]);
    endfunction

    // Output encoding of a completed window sum (0..2*DECIM).
    function automatic logic [OUTW-1:0] encode_sample(input logic [OUTW-1:0] sum);
`ifdef SD_DECIM_SIGNED_EN
        logic signed [OUTW-1:0] bipolar;
        bipolar = $signed(sum) - $signed(OUTW'(DECIM));
        return bipolar;
`else
        return sum;
`endif
    endfunction

    logic [OUTW-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUTW-1:0]  dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             ovr_q, ovr_d;

    logic [OUTW-1:0]  window_sum;
    logic             dump;

    // Window accumulation: add this clock's increment, or dump the finished window.
    always_comb begin
        window_sum = acc_q + popcount2(sd_in);
        dump       = en && (cnt_q == CNT_LAST);
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        if (en) begin
            if (dump) begin
                acc_d  = '0;
                cnt_d  = '0;
                dout_d = encode_sample(window_sum);
            end else begin
                acc_d = window_sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Handshake and overrun: a dump always (re)validates dout; set of ovr beats clear.
    always_comb begin
        dout_valid_d = dout_valid_q;
        ovr_d        = ovr_q;
        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end
        if (ovr_clr) begin
            ovr_d = 1'b0;
        end
        if (dump) begin
            dout_valid_d = 1'b1;
            if (dout_valid_q && !dout_ready) begin
                ovr_d = 1'b1;
            end
        end
    end

    // State registers; reset discards any partial window and pending sample at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            ovr_q        <= ovr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign ovr        = ovr_q;

endmodule

// File: tb/tb_sd_decimator.sv
// Bench for sd_decimator with DECIM=4, OUTW=4. Stimulus pushes the expected
// {dout, ovr} of every window it completes; a monitor pops one entry each time
// the DUT presents a new sample. Honours SD_DECIM_SIGNED_EN for the encoding.
module tb_sd_decimator;

    logic       clk;
    logic       reset;
    logic [1:0] sd_in;
    logic       en;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       ovr;
    logic       ovr_clr;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] d;
        logic       o;
    } exp_t;

    exp_t sb_q[$];

    sd_decimator #(.DECIM(4), .OUTW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .sd_in      (sd_in),
        .en         (en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .ovr        (ovr),
        .ovr_clr    (ovr_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] enc(input int s);
`ifdef SD_DECIM_SIGNED_EN
        return 4'(s - 4);
`else
        return 4'(s);
`endif
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int s, input logic o);
        exp_t e;
        e.d = enc(s);
        e.o = o;
        sb_q.push_back(e);
    endtask

    // One clock with the given inputs; returns 1 time unit after the rising edge.
    task automatic cyc(input logic [1:0] sd, input logic e, input logic rdy, input logic clr);
        sd_in      = sd;
        en         = e;
        dout_ready = rdy;
        ovr_clr    = clr;
        @(posedge clk);
        #1;
    endtask

    // Monitor: a new sample is valid rising, or a change of dout while valid stays high.
    logic       prev_valid = 1'b0;
    logic [3:0] prev_dout  = 4'h0;
    always @(negedge clk) begin
        if (reset && dout_valid && (!prev_valid || dout !== prev_dout)) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_sample: got dout=%0h ovr=%0b expected none at %0t",
                         dout, ovr, $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (dout !== e.d || ovr !== e.o) begin
                    failures++;
                    $display("FAIL sample: got dout=%0h ovr=%0b expected dout=%0h ovr=%0b at %0t",
                             dout, ovr, e.d, e.o, $time);
                end
            end
        end
        prev_valid = dout_valid;
        prev_dout  = dout;
    end

    initial begin
        reset      = 1'b0;
        sd_in      = 2'b00;
        en         = 1'b0;
        dout_ready = 1'b1;
        ovr_clr    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dout", dout, 4'h0);
        chk("reset_valid", {3'b0, dout_valid}, 4'h0);
        chk("reset_ovr", {3'b0, ovr}, 4'h0);
        reset = 1'b1;
        cyc(2'b00, 1'b0, 1'b1, 1'b0);

        // Full-scale window: visible right after the fourth edge.
        push(8, 1'b0);
        for (int i = 0; i < 3; i++) cyc(2'b11, 1'b1, 1'b1, 1'b0);
        chk("full_not_early", {3'b0, dout_valid}, 4'h0);
        cyc(2'b11, 1'b1, 1'b1, 1'b0);
        chk("full_valid", {3'b0, dout_valid}, 4'h1);
        cyc(2'b00, 1'b0, 1'b1, 1'b0);
        chk("handshake_clears", {3'b0, dout_valid}, 4'h0);

        // Mid-scale and zero windows.
        push(4, 1'b0);
        for (int i = 0; i < 4; i++) cyc(2'b01, 1'b1, 1'b1, 1'b0);
        cyc(2'b00, 1'b0, 1'b1, 1'b0);
        push(0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(2'b00, 1'b1, 1'b1, 1'b0);
        cyc(2'b00, 1'b0, 1'b1, 1'b0);

        // Qualifier toggling: only every other clock counts.
        push(4, 1'b0);
        for (int i = 0; i < 7; i++) cyc(2'b10, 1'(i % 2), 1'b1, 1'b0);
        chk("en_gap_not_early", {3'b0, dout_valid}, 4'h0);
        cyc(2'b10, 1'b1, 1'b1, 1'b0);
        chk("en_gap_valid", {3'b0, dout_valid}, 4'h1);
        cyc(2'b00, 1'b0, 1'b1, 1'b0);

        // Overrun: two windows unconsumed, then clear, then clear coincident with set.
        push(8, 1'b0);
        for (int i = 0; i < 4; i++) cyc(2'b11, 1'b1, 1'b0, 1'b0);
        push(2, 1'b1);
        cyc(2'b01, 1'b1, 1'b0, 1'b0);
        cyc(2'b01, 1'b1, 1'b0, 1'b0);
        cyc(2'b00, 1'b1, 1'b0, 1'b0);
        cyc(2'b00, 1'b1, 1'b0, 1'b0);
        chk("ovr_set", {3'b0, ovr}, 4'h1);
        cyc(2'b00, 1'b0, 1'b0, 1'b1);
        chk("ovr_cleared", {3'b0, ovr}, 4'h0);
        chk("dout_held", dout, enc(2));
        chk("valid_held", {3'b0, dout_valid}, 4'h1);
        push(5, 1'b1);
        cyc(2'b11, 1'b1, 1'b0, 1'b0);
        cyc(2'b11, 1'b1, 1'b0, 1'b0);
        cyc(2'b01, 1'b1, 1'b0, 1'b0);
        cyc(2'b00, 1'b1, 1'b0, 1'b1);
        chk("ovr_set_wins", {3'b0, ovr}, 4'h1);
        cyc(2'b00, 1'b0, 1'b1, 1'b1);
        chk("ovr_clr2", {3'b0, ovr}, 4'h0);
        chk("valid_consumed", {3'b0, dout_valid}, 4'h0);

        // Ready asserted on the dump edge while a sample is pending: no overrun.
        push(8, 1'b0);
        for (int i = 0; i < 4; i++) cyc(2'b11, 1'b1, 1'b0, 1'b0);
        push(2, 1'b0);
        cyc(2'b10, 1'b1, 1'b0, 1'b0);
        cyc(2'b01, 1'b1, 1'b0, 1'b0);
        cyc(2'b00, 1'b1, 1'b0, 1'b0);
        cyc(2'b00, 1'b1, 1'b1, 1'b0);
        chk("dump_ready_valid", {3'b0, dout_valid}, 4'h1);
        chk("dump_ready_ovr", {3'b0, ovr}, 4'h0);
        cyc(2'b00, 1'b0, 1'b1, 1'b0);
        chk("dump_ready_consumed", {3'b0, dout_valid}, 4'h0);

        // Mid-window asynchronous reset with a pending sample and ovr set.
        push(8, 1'b0);
        for (int i = 0; i < 4; i++) cyc(2'b11, 1'b1, 1'b0, 1'b0);
        push(3, 1'b1);
        for (int i = 0; i < 3; i++) cyc(2'b01, 1'b1, 1'b0, 1'b0);
        cyc(2'b00, 1'b1, 1'b0, 1'b0);
        cyc(2'b11, 1'b1, 1'b0, 1'b0);
        cyc(2'b11, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_dout", dout, 4'h0);
        chk("async_rst_valid", {3'b0, dout_valid}, 4'h0);
        chk("async_rst_ovr", {3'b0, ovr}, 4'h0);
        cyc(2'b11, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        push(8, 1'b0);
        for (int i = 0; i < 2; i++) cyc(2'b11, 1'b1, 1'b1, 1'b0);
        chk("post_rst_2", {3'b0, dout_valid}, 4'h0);
        cyc(2'b11, 1'b1, 1'b1, 1'b0);
        chk("post_rst_3", {3'b0, dout_valid}, 4'h0);
        cyc(2'b11, 1'b1, 1'b1, 1'b0);
        chk("post_rst_4", {3'b0, dout_valid}, 4'h1);
        repeat (3) cyc(2'b00, 1'b0, 1'b1, 1'b0);

        chk("scoreboard_drained", 4'(sb_q.size()), 4'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
